interrupt_controller: RTL

- Parametrised interrupt front-end for the 6502-style core.
- Takes raw asynchronous interrupt pins: one NMI plus NUM_IRQ maskable IRQ channels.
- Synchronises and conditions each pin, latches pending state, and arbitrates by fixed priority.
- Hands one request at a time to the instruction loader over a req/ack handshake, and drives the PSR I-flag set/clear strobes.

---
 rtl/interrupt_controller_pkg.sv | 17 +
 rtl/interrupt_controller_sync.sv | 24 ++
 rtl/interrupt_controller.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/interrupt_controller_pkg.sv
// Shared definitions for the interrupt front-end: FSM state encoding and the
// vector addresses the instruction loader fetches for reset, NMI and IRQ.
package interrupt_controller_pkg;

    typedef enum logic [2:0] {
        IDLE,
        REQUEST,
        SERVICE,
        NREQUEST,
        NESTED
    } ic_state_t;

    localparam logic [15:0] NMI_VECTOR   = 16'hFFFA;
    localparam logic [15:0] RESET_VECTOR = 16'hFFFC;
    localparam logic [15:0] IRQ_VECTOR   = 16'hFFFE;

endpackage

// File: rtl/interrupt_controller_sync.sv
// Multi-flop synchroniser for one asynchronous pin; output lags the pin by STAGES cycles.
// No handshake: samples every cycle and cannot stall.
module interrupt_controller_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic nrst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] ff;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            ff <= '0;
        end else begin
            ff <= {ff[STAGES-2:0], d};
        end
    end

    assign q = ff[STAGES-1];

endmodule

// File: rtl/interrupt_controller.sv
// NMI + NUM_IRQ IRQ front-end: pin to intReq in SYNC_STAGES+2 cycles; one request held until intAck.
// NESTED_NMI_EN lets an NMI pre-empt a serviced IRQ (one level deep); otherwise NMIs wait for IDLE.
module interrupt_controller
    import interrupt_controller_pkg::*;
#(
    parameter int                 NUM_IRQ     = 4,
    parameter int                 SYNC_STAGES = 2,
    parameter logic [NUM_IRQ-1:0] EDGE_MASK   = {NUM_IRQ{1'b1}},
    localparam int                ID_W        = ($clog2(NUM_IRQ) > 0) ? $clog2(NUM_IRQ) : 1
) (
    input  logic               clk,
    input  logic               nrst,
    input  logic               nmiIn,
    input  logic [NUM_IRQ-1:0] irqIn,
    input  logic [NUM_IRQ-1:0] irqEnable,
    input  logic               psrIFlag,
    input  logic               intAck,
    input  logic               finishInterrupt,
    output logic               intReq,
    output logic               intIsNmi,
    output logic [ID_W-1:0]    intId,
    output logic               setIFlag,
    output logic               clearIFlag,
    output logic [NUM_IRQ-1:0] pending,
    output logic               busy
);

    logic               nmi_sync, nmi_hist, nmi_pend, nmi_pend_nxt, nmi_ack;
    logic [NUM_IRQ-1:0] irq_sync, irq_hist, pend_q, pend_nxt, eligible;
    logic [ID_W-1:0]    winner, cur_id;
    logic               cur_nmi, load, ack_fire, nack_fire, nest;
    ic_state_t          state, state_nxt;

    interrupt_controller_sync #(.STAGES(SYNC_STAGES)) u_nmi_sync (
        .clk  (clk),
        .nrst (nrst),
        .d    (nmiIn),
        .q    (nmi_sync)
    );

    for (genvar g = 0; g < NUM_IRQ; g++) begin : g_irq_sync
        interrupt_controller_sync #(.STAGES(SYNC_STAGES)) u_sync (
            .clk  (clk),
            .nrst (nrst),
            .d    (irqIn[g]),
            .q    (irq_sync[g])
        );
    end

    assign ack_fire = (state == REQUEST) && intAck;
`ifdef NESTED_NMI_EN
    assign nack_fire = (state == NREQUEST) && intAck;
`else
    assign nack_fire = 1'b0;
`endif
    assign nmi_ack = (ack_fire && cur_nmi) || nack_fire;

    // Clear first, then set, so a fresh edge in the ack cycle is never lost.
    always_comb begin
        pend_nxt = pend_q;
        for (int i = 0; i < NUM_IRQ; i++) begin
            if (EDGE_MASK[i]) begin
                if (ack_fire && !cur_nmi && (cur_id == ID_W'(i))) begin
                    pend_nxt[i] = 1'b0;
                end
                if (irq_sync[i] && !irq_hist[i]) begin
                    pend_nxt[i] = 1'b1;
                end
            end else begin
                pend_nxt[i] = irq_sync[i];
            end
        end
        nmi_pend_nxt = (nmi_pend && !nmi_ack) || (nmi_sync && !nmi_hist);
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            irq_hist <= '0;
            nmi_hist <= 1'b0;
            pend_q   <= '0;
            nmi_pend <= 1'b0;
        end else begin
            irq_hist <= irq_sync;
            nmi_hist <= nmi_sync;
            pend_q   <= pend_nxt;
            nmi_pend <= nmi_pend_nxt;
        end
    end

    assign eligible = pend_q & irqEnable & ~{NUM_IRQ{psrIFlag}};

    always_comb begin
        winner = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                winner = ID_W'(i);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        case (state)
            IDLE: begin
                if (nmi_pend || (|eligible)) begin
                    state_nxt = REQUEST;
                    load      = 1'b1;
                end
            end
            REQUEST: begin
                if (intAck) state_nxt = SERVICE;
            end
            SERVICE: begin
                if (finishInterrupt) begin
                    state_nxt = IDLE;
`ifdef NESTED_NMI_EN
                end else if (!cur_nmi && nmi_pend) begin
                    state_nxt = NREQUEST;
`endif
                end
            end
`ifdef NESTED_NMI_EN
            NREQUEST: begin
                if (intAck) state_nxt = NESTED;
            end
            NESTED: begin
                if (finishInterrupt) state_nxt = SERVICE;
            end
`endif
            default: state_nxt = IDLE;
        endcase
    end

    // cur_id survives the nested NMI untouched and is what SERVICE resumes with.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state   <= IDLE;
            cur_nmi <= 1'b0;
            cur_id  <= '0;
        end else begin
            state <= state_nxt;
            if (load) begin
                cur_nmi <= nmi_pend;
                cur_id  <= nmi_pend ? '0 : winner;
            end
        end
    end

    assign nest       = (state == NREQUEST) || (state == NESTED);
    assign intReq     = (state == REQUEST) || (state == NREQUEST);
    assign intIsNmi   = (state != IDLE) && (cur_nmi || nest);
    assign intId      = ((state == IDLE) || nest || cur_nmi) ? '0 : cur_id;
    assign setIFlag   = ack_fire;
    assign clearIFlag = (state == SERVICE) && finishInterrupt;
    assign busy       = (state == SERVICE) || (state == NESTED);
    assign pending    = pend_q;

endmodule
